// File: rtl/toggle_edge_detect.sv
// Per-bit rise/fall toggle detector with sticky coverage map, saturating covered count and
// all-covered flag. Optional build macro TOGGLE_ONCE_EN: report each point only on first coverage.
module toggle_edge_detect #(
  parameter int unsigned WIDTH = 31,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [WIDTH-1:0]   sig,
  output logic [2*WIDTH-1:0] valid,
  output logic [CNT_W-1:0]   covered_cnt,
  output logic               all_covered
);

  localparam int unsigned NP = 2 * WIDTH;

  localparam logic [0:0] SAMPLE = 1'b0;
  localparam logic [0:0] RUN    = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] sig_q;
  logic [NP-1:0]    covered_q, covered_d;
  logic [NP-1:0]    valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             all_q, all_d;

  logic [NP-1:0]    hit;
  logic [NP-1:0]    new_pts;
  logic [CNT_W:0]   pop;
  logic [CNT_W:0]   sum;

  // Point 2i is bit i rising, point 2i+1 is bit i falling.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      hit[2*i]   = enable & sig[i] & ~sig_q[i];
      hit[2*i+1] = enable & ~sig[i] & sig_q[i];
    end
    new_pts = hit & ~covered_q;
    pop = '0;
    for (int i = 0; i < int'(NP); i++) begin
      pop = pop + {{CNT_W{1'b0}}, new_pts[i]};
    end
    sum = {1'b0, cnt_q} + pop;
  end

  always_comb begin
    state_d   = state_q;
    covered_d = covered_q;
    cnt_d     = cnt_q;
    all_d     = all_q;
    valid_d   = '0;
    if (clear) begin
      state_d   = SAMPLE;
      covered_d = '0;
      cnt_d     = '0;
      all_d     = 1'b0;
    end else if (state_q == SAMPLE) begin
      // Baseline capture only; reset/clear-release values never count as toggles.
      state_d = RUN;
    end else begin
      covered_d = covered_q | new_pts;
      cnt_d     = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
      all_d     = &(covered_q | new_pts);
`ifdef TOGGLE_ONCE_EN
      valid_d   = new_pts;
`else
      valid_d   = hit;
`endif
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= SAMPLE;
      sig_q     <= '0;
      covered_q <= '0;
      valid_q   <= '0;
      cnt_q     <= '0;
      all_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sig_q     <= sig;
      covered_q <= covered_d;
      valid_q   <= valid_d;
      cnt_q     <= cnt_d;
      all_q     <= all_d;
    end
  end

  assign valid       = valid_q;
  assign covered_cnt = cnt_q;
  assign all_covered = all_q;

endmodule

// File: tb/tb_toggle_edge_detect.sv
// Randomized self-checking bench for toggle_edge_detect against a per-point behavioural model.
module tb_toggle_edge_detect;

  localparam int WIDTH = 31;
  localparam int CNT_W = 16;
  localparam int NP    = 2 * WIDTH;

  logic             clock;
  logic             reset;
  logic             enable;
  logic             clear;
  logic [WIDTH-1:0] sig;
  logic [NP-1:0]    valid;
  logic [CNT_W-1:0] covered_cnt;
  logic             all_covered;

  int tests_run;
  int tests_failed;

  // Behavioural model state
  logic [WIDTH-1:0] m_prev;
  bit               m_sampling;
  bit               m_cov [NP];
  int               m_cnt;
  logic [NP-1:0]    m_valid;

  toggle_edge_detect #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .sig         (sig),
    .valid       (valid),
    .covered_cnt (covered_cnt),
    .all_covered (all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev     = '0;
    m_sampling = 1'b1;
    foreach (m_cov[p]) m_cov[p] = 1'b0;
    m_cnt      = 0;
    m_valid    = '0;
  endtask

  task automatic model_edge(input logic [WIDTH-1:0] s, input logic en, input logic clr);
    m_valid = '0;
    if (clr) begin
      foreach (m_cov[p]) m_cov[p] = 1'b0;
      m_cnt      = 0;
      m_sampling = 1'b1;
    end else if (m_sampling) begin
      m_sampling = 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        for (int dir = 0; dir < 2; dir++) begin
          bit ev;
          int p;
          ev = (dir == 0) ? (s[i] && !m_prev[i]) : (!s[i] && m_prev[i]);
          p  = 2 * i + dir;
          if (en && ev) begin
`ifdef TOGGLE_ONCE_EN
            if (!m_cov[p]) m_valid[p] = 1'b1;
`else
            m_valid[p] = 1'b1;
`endif
            if (!m_cov[p]) begin
              m_cov[p] = 1'b1;
              if (m_cnt < (2 ** CNT_W) - 1) m_cnt++;
            end
          end
        end
      end
    end
    m_prev = s;
  endtask

  task automatic compare_model(input string tag);
    check_eq({tag, ".valid"}, 64'(valid), 64'(m_valid));
    check_eq({tag, ".cnt"}, 64'(covered_cnt), 64'(m_cnt));
    check_eq({tag, ".all"}, 64'(all_covered), 64'(m_cnt == NP));
  endtask

  // Inputs change at negedge, DUT captures at posedge, outputs are checked at next negedge.
  task automatic step(input logic [WIDTH-1:0] s, input logic en, input logic clr,
                      input string tag);
    sig    = s;
    enable = en;
    clear  = clr;
    @(posedge clock);
    model_edge(s, en, clr);
    @(negedge clock);
    compare_model(tag);
  endtask

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] cur;
  logic [63:0]      even_mask;
  logic [63:0]      odd_mask;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ones         = '1;
    even_mask    = '0;
    odd_mask     = '0;
    for (int i = 0; i < WIDTH; i++) begin
      even_mask[2*i]   = 1'b1;
      odd_mask[2*i+1]  = 1'b1;
    end

    // Reset held with all-ones bus, then released with the bus unchanged
    reset  = 1'b0;
    enable = 1'b1;
    clear  = 1'b0;
    sig    = ones;
    model_reset();
    repeat (3) @(negedge clock);
    compare_model("reset");
    reset = 1'b1;
    for (int k = 0; k < 3; k++) step(ones, 1'b1, 1'b0, "baseline");
    check_eq("t1_cnt", 64'(covered_cnt), 64'd0);

    // Falls while disabled are lost; bit3 rise then fall
    step('0, 1'b0, 1'b0, "dis_fall");
    step(WIDTH'(8), 1'b1, 1'b0, "b3_rise");
    check_eq("t2_rise", 64'(valid), 64'(1) << 6);
    check_eq("t2_cnt1", 64'(covered_cnt), 64'd1);
    step('0, 1'b1, 1'b0, "b3_fall");
    check_eq("t2_fall", 64'(valid), 64'(1) << 7);
    check_eq("t2_cnt2", 64'(covered_cnt), 64'd2);
    step(WIDTH'(8), 1'b1, 1'b0, "b3_rise2");
`ifdef TOGGLE_ONCE_EN
    check_eq("t3_rise2", 64'(valid), 64'd0);
`else
    check_eq("t3_rise2", 64'(valid), 64'(1) << 6);
`endif
    check_eq("t3_cnt", 64'(covered_cnt), 64'd2);
    step('0, 1'b1, 1'b0, "b3_fall2");

    // Bit0 rise while disabled is never reported
    step(WIDTH'(1), 1'b0, 1'b0, "b0_rise_dis");
    step(WIDTH'(1), 1'b1, 1'b0, "b0_hold");
    check_eq("t5_nopulse", 64'(valid), 64'd0);
    step('0, 1'b1, 1'b0, "b0_fall");
    check_eq("t5_fall", 64'(valid), 64'(1) << 1);

    // Clear wins over a simultaneous bit5 rise; next edge is a baseline sample
    step(WIDTH'(32), 1'b1, 1'b1, "clr_b5");
    check_eq("t6_clr_valid", 64'(valid), 64'd0);
    check_eq("t6_clr_cnt", 64'(covered_cnt), 64'd0);
    step(WIDTH'(32), 1'b1, 1'b0, "sample_b5");
    check_eq("t6_sample", 64'(valid), 64'd0);
    step('0, 1'b1, 1'b0, "b5_fall");
    check_eq("t6_fall", 64'(valid), 64'(1) << 11);
    check_eq("t6_cnt", 64'(covered_cnt), 64'd1);

    // Full sweep 0 -> all-ones -> 0 after a clear
    step('0, 1'b1, 1'b1, "sweep_clr");
    step('0, 1'b1, 1'b0, "sweep_sample");
    step(ones, 1'b1, 1'b0, "sweep_up");
    check_eq("t4_even", 64'(valid), even_mask);
    step('0, 1'b1, 1'b0, "sweep_down");
    check_eq("t4_odd", 64'(valid), odd_mask);
    check_eq("t4_cnt", 64'(covered_cnt), 64'(NP));
    check_eq("t4_all", 64'(all_covered), 64'd1);

    // Randomized phase
    cur = '0;
    for (int n = 0; n < 1500; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 3) cur = WIDTH'($urandom);
      else if (r < 8) cur[$urandom_range(0, WIDTH - 1)] ^= 1'b1;
      step(cur, ($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0), "rand");
    end

    // Asynchronous reset mid-run clears outputs without a clock edge
    step(~cur, 1'b1, 1'b0, "pre_rst");
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("rst_valid", 64'(valid), 64'd0);
    check_eq("rst_cnt", 64'(covered_cnt), 64'd0);
    check_eq("rst_all", 64'(all_covered), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int n = 0; n < 200; n++) begin
      cur = WIDTH'($urandom);
      step(cur, 1'b1, 1'b0, "post_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
